// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the shared open-drain lines.
// Define LED_SYNC_EN to add the automatic set-LEDs (ED nn) sequencer driven by leds/rx_*.
module ps2_host_tx #(
  parameter int unsigned INHIBIT  = 120,
  parameter int unsigned START_TO = 15000,
  parameter int unsigned FRAME_TO = 2000,
  parameter int unsigned RESP_TO  = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2_ck,
  input  logic       ps2_dt,
  output logic       ck_oe,
  output logic       dt_oe,
  input  logic       send,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic [2:0] leds,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  localparam int unsigned TMAX0 = (START_TO > INHIBIT) ? START_TO : INHIBIT;
  localparam int unsigned TMAX  = (TMAX0 > FRAME_TO) ? TMAX0 : FRAME_TO;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TO - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_REQ, ST_DATA, ST_ACK, ST_WAITHI
  } tx_state_t;

  // ---------------- input conditioning ----------------
  logic [1:0] ck_sync_q, dt_sync_q;
  logic       ck_f_q, ck_f_d;
  logic [1:0] flt_q, flt_d;
  logic       ck_s, dt_s, fall;

  assign ck_s = ck_sync_q[1];
  assign dt_s = dt_sync_q[1];

  // Filtered clock only follows the synchronised clock after 4 consecutive differing ticks.
  always_comb begin
    ck_f_d = ck_f_q;
    flt_d  = '0;
    fall   = 1'b0;
    if (ck_s != ck_f_q) begin
      if (flt_q == 2'd3) begin
        ck_f_d = ck_s;
        fall   = ck_f_q;
      end else begin
        flt_d = flt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync_q <= '1;
      dt_sync_q <= '1;
      ck_f_q    <= 1'b1;
      flt_q     <= '0;
    end else if (ce) begin
      ck_sync_q <= {ck_sync_q[0], ps2_ck};
      dt_sync_q <= {dt_sync_q[0], ps2_dt};
      ck_f_q    <= ck_f_d;
      flt_q     <= flt_d;
    end
  end

  // ---------------- request source ----------------
  logic       req;
  logic [7:0] req_byte;
  logic       seq_err;

  // ---------------- transmit FSM ----------------
  tx_state_t   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        par_q, par_d;
  logic        ck_oe_q, ck_oe_d, dt_oe_q, dt_oe_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        tx_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    par_d   = par_q;
    ck_oe_d = ck_oe_q;
    dt_oe_d = dt_oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_INHIBIT;
          byte_d  = req_byte;
          par_d   = ~^req_byte;
          busy_d  = 1'b1;
          ck_oe_d = 1'b1;
          dt_oe_d = 1'b0;
          cnt_d   = '0;
          fcnt_d  = '0;
          idx_d   = '0;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = ST_REQ;
          ck_oe_d = 1'b0;
          dt_oe_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_REQ: begin
        if (fall) begin
          state_d = ST_DATA;
          dt_oe_d = ~byte_q[0];
          idx_d   = 4'd1;
          fcnt_d  = '0;
        end else if (cnt_q == START_LAST) begin
          tx_err = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (fall) begin
          if (idx_q < 4'd8) begin
            dt_oe_d = ~byte_q[idx_q[2:0]];
          end else if (idx_q == 4'd8) begin
            dt_oe_d = ~par_q;
          end else begin
            dt_oe_d = 1'b0;
            state_d = ST_ACK;
          end
          idx_d = idx_q + 4'd1;
        end
      end
      ST_ACK: begin
        if (fall) begin
          if (!dt_s) state_d = ST_WAITHI;
          else       tx_err  = 1'b1;
        end
      end
      ST_WAITHI: begin
        if (ck_f_q && dt_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame timer covers first fall through WAITHI; a completing frame beats the timeout.
    if (state_q inside {ST_DATA, ST_ACK, ST_WAITHI}) begin
      if (fcnt_q == FRAME_LAST && !done_d) tx_err = 1'b1;
      else                                 fcnt_d = fcnt_q + TW'(1);
    end

    if (tx_err) begin
      state_d = ST_IDLE;
      ck_oe_d = 1'b0;
      dt_oe_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      fcnt_d  = '0;
    end
  end

  assign err_d = tx_err | seq_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
      ck_oe_q <= 1'b0;
      dt_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      ck_oe_q <= ck_oe_d;
      dt_oe_q <= dt_oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ck_oe = ck_oe_q;
  assign dt_oe = dt_oe_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = err_q;

`ifdef LED_SYNC_EN
  // ---------------- LED sequencer ----------------
  localparam int unsigned RW = $clog2(RESP_TO + 1);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESP_TO - 1);

  typedef enum logic [2:0] {
    SQ_IDLE, SQ_ED, SQ_FA, SQ_VAL_REQ, SQ_VAL
  } seq_state_t;

  seq_state_t    sq_q, sq_d;
  logic          dirty_q, dirty_d;
  logic [2:0]    leds_q;
  logic [RW-1:0] rt_q, rt_d;
  logic          seq_go;
  logic [7:0]    seq_byte;
  logic          leds_chg;

  assign leds_chg = (leds != leds_q);

  // Sequencer follows tx completion through the registered done/error pulses,
  // which keeps it free of a combinational path back through the request mux.
  always_comb begin
    sq_d     = sq_q;
    dirty_d  = dirty_q | leds_chg;
    rt_d     = rt_q;
    seq_go   = 1'b0;
    seq_byte = 8'hED;
    seq_err  = 1'b0;
    case (sq_q)
      SQ_IDLE: begin
        if (dirty_q && state_q == ST_IDLE && !send) begin
          seq_go  = 1'b1;
          sq_d    = SQ_ED;
          dirty_d = leds_chg;
        end
      end
      SQ_ED: begin
        if (done_q) begin
          sq_d = SQ_FA;
          rt_d = '0;
        end else if (err_q) begin
          sq_d    = SQ_IDLE;
          dirty_d = 1'b1;
        end
      end
      SQ_FA: begin
        if (rx_valid && rx_data == 8'hFA) begin
          sq_d = SQ_VAL_REQ;
        end else if (rt_q == RESP_LAST) begin
          if (state_q == ST_IDLE) begin
            seq_err = 1'b1;
            sq_d    = SQ_IDLE;
            dirty_d = 1'b1;
          end
        end else begin
          rt_d = rt_q + RW'(1);
        end
      end
      SQ_VAL_REQ: begin
        seq_byte = {5'b0, leds};
        if (state_q == ST_IDLE && !send) begin
          seq_go = 1'b1;
          sq_d   = SQ_VAL;
        end
      end
      SQ_VAL: begin
        if (done_q) begin
          sq_d = SQ_IDLE;
        end else if (err_q) begin
          sq_d    = SQ_IDLE;
          dirty_d = 1'b1;
        end
      end
      default: sq_d = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sq_q    <= SQ_IDLE;
      dirty_q <= 1'b1;
      leds_q  <= '0;
      rt_q    <= '0;
    end else if (ce) begin
      sq_q    <= sq_d;
      dirty_q <= dirty_d;
      leds_q  <= leds;
      rt_q    <= rt_d;
    end
  end

  assign req      = send | seq_go;
  assign req_byte = send ? cmd : seq_byte;
`else
  logic unused_led_inputs;
  assign unused_led_inputs = ^{leds, rx_valid, rx_data};
  assign seq_err  = 1'b0;
  assign req      = send;
  assign req_byte = cmd;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural PS/2 device receives frames, monitors compare.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int unsigned INHIBIT  = 120;
  localparam int unsigned START_TO = 15000;
  localparam int unsigned FRAME_TO = 2000;
  localparam int unsigned RESP_TO  = 20000;
  localparam int HALF = 40;

  logic clock = 1'b0, reset = 1'b0, ce = 1'b1, send = 1'b0, rx_valid = 1'b0;
  logic [7:0] cmd = '0, rx_data = '0;
  logic [2:0] leds = '0;
  logic ck_oe, dt_oe, busy, done, error;
  logic dev_ck = 1'b1, dev_dt = 1'b1;
  logic ps2_ck, ps2_dt;

  assign ps2_ck = dev_ck & ~ck_oe;
  assign ps2_dt = dev_dt & ~dt_oe;

  ps2_host_tx #(.INHIBIT(INHIBIT), .START_TO(START_TO), .FRAME_TO(FRAME_TO), .RESP_TO(RESP_TO)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2_ck(ps2_ck), .ps2_dt(ps2_dt),
    .ck_oe(ck_oe), .dt_oe(dt_oe), .send(send), .cmd(cmd), .busy(busy),
    .done(done), .error(error), .leds(leds), .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int cyc = 0, t_done = 0, t_err = 0;
  logic [7:0] exp_bytes[$];
  int exp_stat[$];       // 1 = done expected, 2 = error expected
  int dev_mode = 0;      // 0 = acks, 1 = never clocks, 2 = no ack
  bit fa_en = 1'b1, dev_abort = 1'b0;
  int dev_falls = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device model: answers a request-to-send by clocking 11 bits and sampling before each rise.
  initial begin : device
    logic [10:0] bits;
    logic [7:0]  e;
    bit aborted;
    forever begin
      @(negedge clock);
      if (reset && ps2_ck && !ps2_dt && dev_mode != 1) begin
        aborted = 1'b0;
        bits = '0;
        repeat (50) @(negedge clock);
        for (int k = 1; k <= 11 && !aborted; k++) begin
          dev_ck = 1'b0;
          dev_falls = k;
          repeat (HALF) @(negedge clock);
          bits[k-1] = ps2_dt;
          dev_ck = 1'b1;
          if (k == 10 && dev_mode == 0) dev_dt = 1'b0;
          if (k == 11) dev_dt = 1'b1;
          repeat (HALF) @(negedge clock);
          if (dev_abort) aborted = 1'b1;
        end
        dev_ck = 1'b1;
        dev_dt = 1'b1;
        if (!aborted) begin
          if (exp_bytes.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame: unexpected byte %0h expected none", bits[7:0]);
          end else begin
            e = exp_bytes.pop_front();
            check("byte", 32'(bits[7:0]), 32'(e));
            check("parity", 32'(bits[8]), ($countones(e) % 2 == 0) ? 32'd1 : 32'd0);
            check("stop", 32'(bits[9]), 32'd1);
          end
          if (bits[7:0] == 8'hED && fa_en) begin
            repeat (20) @(negedge clock);
            rx_data = 8'hFA; rx_valid = 1'b1;
            @(negedge clock);
            rx_valid = 1'b0;
          end
        end
      end
    end
  end

  // Status monitor: every done/error pulse is matched against the expected outcome queue.
  initial begin : status_mon
    int s;
    forever begin
      @(negedge clock);
      if (done || error) begin
        check("status_excl", 32'(done & error), 32'd0);
        if (done) t_done = cyc;
        if (error) t_err = cyc;
        if (exp_stat.size() == 0) begin
          checks++; errors++;
          $display("FAIL status: got done=%0b error=%0b expected no pulse", done, error);
        end else begin
          s = exp_stat.pop_front();
          check("status", 32'({done, error}), (s == 1) ? 32'd2 : 32'd1);
        end
        if (done)  check("lines_high_at_done", 32'({ps2_ck, ps2_dt}), 32'd3);
        if (error) check("lines_free_at_error", 32'({ck_oe, dt_oe}), 32'd0);
      end
    end
  end

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_stat.size() != 0 || exp_bytes.size() != 0) && n < limit) begin
      @(negedge clock); n++;
    end
    check("drain", 32'(exp_stat.size() + exp_bytes.size()), 32'd0);
  endtask

  task automatic do_send(input logic [7:0] c, input int mode);
    int n, m;
    dev_mode = mode;
    exp_stat.push_back(mode == 0 ? 1 : 2);
    if (mode != 1) exp_bytes.push_back(c);
    @(negedge clock);
    cmd = c; send = 1'b1;
    @(negedge clock);
    send = 1'b0; cmd = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (ck_oe && n < 1000) begin
      n++; @(negedge clock);
    end
    check("inhibit_len", 32'(n), 32'(INHIBIT));
    check("req_start_bit", 32'(dt_oe), 32'd1);
    if (mode == 1) begin
      m = 0;
      while (!error && m < int'(START_TO) + 100) begin
        @(negedge clock); m++;
      end
      check("start_timeout", 32'(m), 32'(START_TO));
      wait_drain(100);
    end else begin
      cmd = 8'($urandom); send = 1'b1;  // ignored while busy
      @(negedge clock);
      send = 1'b0;
      wait_drain(5000);
    end
    check("busy_end", 32'(busy), 32'd0);
    repeat (100) @(negedge clock);
    dev_mode = 0;
  endtask

  initial begin : watchdog
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (5) @(negedge clock);
    check("reset_state", 32'({ck_oe, dt_oe, busy, done, error}), 32'd0);
`ifdef LED_SYNC_EN
    exp_bytes.push_back(8'hED); exp_bytes.push_back(8'h00);
    exp_stat.push_back(1); exp_stat.push_back(1);
    reset = 1'b1;
    wait_drain(6000);
    repeat (200) @(negedge clock);
    exp_bytes.push_back(8'hED); exp_bytes.push_back(8'h04);
    exp_stat.push_back(1); exp_stat.push_back(1);
    leds = 3'b100;
    wait_drain(6000);
    repeat (200) @(negedge clock);
    fa_en = 1'b0;
    exp_bytes.push_back(8'hED);
    exp_stat.push_back(1); exp_stat.push_back(2);
    leds = 3'b001;
    wait_drain(int'(RESP_TO) + 6000);
    check("resp_timeout_window",
          32'((t_err - t_done) >= int'(RESP_TO) && (t_err - t_done) <= int'(RESP_TO) + 3), 32'd1);
    fa_en = 1'b1;
    exp_bytes.push_back(8'hED); exp_bytes.push_back(8'h01);
    exp_stat.push_back(1); exp_stat.push_back(1);
    wait_drain(6000);
    repeat (200) @(negedge clock);
`else
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_reset", 32'({ck_oe, dt_oe, busy, done, error}), 32'd0);
    do_send(8'hF4, 0);
    do_send(8'hED, 0);
    do_send(8'($urandom), 1);
    do_send(8'($urandom), 2);
    do_send(8'($urandom), 0);

    // Reset while the host is driving data bit 4 (0 for A5, so dt_oe is active).
    dev_falls = 0;
    @(negedge clock);
    cmd = 8'hA5; send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    n = 0;
    while (dev_falls < 5 && n < 3000) begin
      @(negedge clock); n++;
    end
    check("reach_bit4", 32'(dev_falls), 32'd5);
    repeat (20) @(negedge clock);
    check("dt_bit4_driven", 32'(dt_oe), 32'd1);
    #2 reset = 1'b0; dev_abort = 1'b1;
    #1 check("async_release", 32'({ck_oe, dt_oe, busy, done, error}), 32'd0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    repeat (200) @(negedge clock);
    dev_abort = 1'b0;
    check("busy_after_reset", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_send(8'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    n = 0;
    leds = 3'b111;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (busy) n++;
    end
    check("leds_ignored", 32'(n), 32'd0);
`endif
    check("queues_empty", 32'(exp_stat.size() + exp_bytes.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter that shares the keyboard's ps2 clock/data lines with the scancode decoder.
- Sends single command bytes to the keyboard, such as reset (FF), enable (F4) and set-LEDs (ED nn).
- Drives the lines open-drain through output-enable pins and reports busy/done/error.
- Optionally sequences LED updates from the machine's shift-lock state automatically.

Parameters:
- INHIBIT, 120: ce ticks the clock line is held low before the request-to-send (>=100 us at 1 MHz ce).
- START_TO, 15000: ce ticks allowed from request to the first device falling edge.
- FRAME_TO, 2000: ce ticks allowed from the first falling edge to the ack.
- RESP_TO, 20000: ce ticks allowed for the FA response (LED sequencer only).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous active-low reset.
- ce, in, 1: clock enable; all sequential logic except reset advances only when ce=1.
- ps2_ck, in, 1: ps2 clock line as seen at the pad.
- ps2_dt, in, 1: ps2 data line as seen at the pad.
- ck_oe, out, 1: 1 = pull ps2 clock low.
- dt_oe, out, 1: 1 = pull ps2 data low.
- send, in, 1: request strobe, sampled when ce=1.
- cmd, in, 8: byte to send, captured when send is accepted.
- busy, out, 1: transfer in progress.
- done, out, 1: one-ce-tick pulse when the ack is received.
- error, out, 1: one-ce-tick pulse on timeout or missing ack.
- leds, in, 3: {caps, num, scroll} desired LED state.
- rx_valid, in, 1: decoder byte strobe.
- rx_data, in, 8: decoder byte.

Behaviour:
- Reset (asynchronous, reset=0):
  - ck_oe=0, dt_oe=0, busy=0, done=0, error=0, state IDLE, counters 0.
  - Line release is immediate, not clocked.
- Input conditioning:
  - ps2_ck and ps2_dt pass through a 2-FF synchroniser.
  - The clock is then filtered: it must be stable for 4 consecutive ce ticks to change level.
  - A "fall" is a filtered 1->0 transition.
- Accepting a request:
  - send is accepted only in IDLE; send while busy is ignored.
  - On acceptance, cmd is latched, odd parity = ~^cmd, busy=1 on the same tick.
- FSM (one step per ce tick):
  - IDLE: waits for send.
  - INHIBIT: ck_oe=1, dt_oe=0 for INHIBIT ticks.
  - REQ: dt_oe=1 (start bit), ck_oe=0; timer START_TO; first fall -> DATA with bit index 0.
  - DATA: on each fall, drive dt_oe = ~bit in this order: d0..d7, then parity. The 10th fall releases data (stop).
  - ACK: on the 11th fall, sample data. 0 -> WAITHI; 1 -> error.
  - WAITHI: both filtered lines high -> IDLE, done pulse, busy=0.
  - The FRAME_TO timer runs from the first fall through WAITHI.
- Errors:
  - Any timeout or a missing ack releases both lines on the same tick.
  - error pulses for 1 tick, busy=0, state IDLE.
  - done and error are never asserted together.
- Reset mid-transfer: lines are released at once, with no pulses.
- Bit order is LSB first, and bit index wraps only via return to IDLE.

Optional Feature:
- LED_SYNC_EN defined:
  - A sequencer watches leds. Any change, or the first tick after reset, marks "dirty".
  - When IDLE and dirty, the sequencer sends ED, then waits for rx_valid with rx_data=FA within RESP_TO, then sends {5'b0,leds}.
  - dirty clears at the start of the ED send. A change during the sequence re-marks dirty and another sequence follows.
  - An external send in the same tick as a sequencer start wins; the sequencer waits for IDLE.
  - A missing FA or a transmit error abandons the sequence, pulses error, and keeps dirty set for a retry on the next IDLE.
- LED_SYNC_EN undefined: leds, rx_valid and rx_data are ignored; only external send is used.

Test Plan:
- send with cmd=F4, device model clocks 11 falls, ack low -> ck_oe high for 120 ticks; data bits 0,0,1,0,1,1,1,1; parity 0; done pulse; busy 1->0.
- send with cmd=ED -> parity bit 1; dt_oe released on fall 10; done after both lines are high.
- Device never clocks -> error pulse exactly START_TO ticks after REQ entry; ck_oe=0, dt_oe=0.
- Ack bit high on fall 11 -> error pulse, no done; a second send is then accepted normally.
- Assert reset (low) during DATA at bit 4 -> ck_oe and dt_oe drop to 0 asynchronously; after release, busy=0 and no done/error pulses.
- LED_SYNC_EN, leds 000->100 -> ED sent; model replies FA; byte 04 sent; done pulses twice; with no FA -> error after RESP_TO, then a retry.
